// File: rtl/glitch_host_bridge_pkg.sv
// Shared types and constants for glitch_host_bridge: FSM state encodings,
// response codes and command byte field positions.
package glitch_host_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_GET_DATA    = 3'd1,
        ST_WB_CYCLE    = 3'd2,
        ST_SEND_STATUS = 3'd3,
        ST_SEND_DATA   = 3'd4
    } bridge_state_e;

    localparam logic [7:0] RSP_OK     = 8'hA5;
    localparam logic [7:0] RSP_BADCMD = 8'hE1;
    localparam logic [7:0] RSP_RXTO   = 8'hE2;
    localparam logic [7:0] RSP_WBTO   = 8'hEE;

    localparam int CMD_WR_BIT = 7;
    localparam int CMD_RSV_HI = 6;
    localparam int CMD_RSV_LO = 4;
    localparam int CMD_ADR_HI = 3;
    localparam int CMD_ADR_LO = 0;

    // Reserved bits must be zero for a command to be legal.
    function automatic logic cmd_is_bad(input logic [7:0] cmd);
        return cmd[CMD_RSV_HI:CMD_RSV_LO] != 3'b000;
    endfunction

endpackage

// File: rtl/glitch_host_bridge_if.sv
// Byte-stream RX/TX and Wishbone master signals of glitch_host_bridge.
// TX: a byte moves when tx_valid && tx_ready; tx_valid/tx_data hold until then.
interface glitch_host_bridge_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [5:2] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       we_o;
    logic       stb_o;
    logic       ack_i;
    logic       rx_drop;

    modport master (
        input  rx_data, rx_valid, tx_ready, dat_i, ack_i,
        output tx_data, tx_valid, adr_o, dat_o, we_o, stb_o, rx_drop
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dat_i, ack_i,
        input  tx_data, tx_valid, adr_o, dat_o, we_o, stb_o, rx_drop
    );
endinterface

// File: rtl/glitch_host_bridge_timer.sv
// Loadable down-counter that stops at zero; expired_o is high while the count is zero.
module glitch_host_bridge_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/glitch_host_bridge.sv
// Host byte-stream to single Wishbone cycle bridge with status/data responses.
// Define GLITCH_BRIDGE_RXTO_EN to abandon a write whose data byte never arrives.
module glitch_host_bridge
    import glitch_host_bridge_pkg::*;
#(
    parameter int WB_TIMEOUT = 16,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    glitch_host_bridge_if.master bus,
    output bridge_state_e        dbg_state_o
);
    bridge_state_e state_q, state_d;
    logic [3:0]    adr_q, adr_d;
    logic [7:0]    dat_q, dat_d;
    logic          we_q, we_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          has_data_q, has_data_d;
    logic          wb_load, wb_expired, rx_expired;
    logic          tx_valid, rx_drop;
    logic [7:0]    tx_data;

    // Loaded with WB_TIMEOUT-1 so that stb_o stays high exactly WB_TIMEOUT cycles.
    glitch_host_bridge_timer #(.WIDTH(8)) u_wb_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wb_load),
        .load_val_i (8'(WB_TIMEOUT - 1)),
        .en_i       (state_q == ST_WB_CYCLE),
        .expired_o  (wb_expired)
    );

`ifdef GLITCH_BRIDGE_RXTO_EN
    localparam int RX_W = $clog2(RX_TIMEOUT + 1);
    logic rx_load;

    assign rx_load = (state_q == ST_IDLE) && bus.rx_valid && bus.rx_data[CMD_WR_BIT]
                     && !cmd_is_bad(bus.rx_data);

    glitch_host_bridge_timer #(.WIDTH(RX_W)) u_rx_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (rx_load),
        .load_val_i (RX_W'(RX_TIMEOUT - 1)),
        .en_i       (state_q == ST_GET_DATA),
        .expired_o  (rx_expired)
    );
`else
    assign rx_expired = (RX_TIMEOUT < 0);
`endif

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        status_d   = status_q;
        rdata_d    = rdata_q;
        has_data_d = has_data_q;
        wb_load    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        rx_drop    = bus.rx_valid && (state_q != ST_IDLE) && (state_q != ST_GET_DATA);
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (cmd_is_bad(bus.rx_data)) begin
                        status_d   = RSP_BADCMD;
                        has_data_d = 1'b0;
                        state_d    = ST_SEND_STATUS;
                    end else begin
                        adr_d = bus.rx_data[CMD_ADR_HI:CMD_ADR_LO];
                        we_d  = 1'b0;
                        if (bus.rx_data[CMD_WR_BIT]) begin
                            state_d = ST_GET_DATA;
                        end else begin
                            has_data_d = 1'b1;
                            wb_load    = 1'b1;
                            state_d    = ST_WB_CYCLE;
                        end
                    end
                end
            end
            ST_GET_DATA: begin
                // A data byte in the RX expiry cycle still wins.
                if (bus.rx_valid) begin
                    dat_d      = bus.rx_data;
                    we_d       = 1'b1;
                    has_data_d = 1'b0;
                    wb_load    = 1'b1;
                    state_d    = ST_WB_CYCLE;
                end else if (rx_expired) begin
                    status_d   = RSP_RXTO;
                    has_data_d = 1'b0;
                    state_d    = ST_SEND_STATUS;
                end
            end
            ST_WB_CYCLE: begin
                if (bus.ack_i) begin
                    status_d = RSP_OK;
                    if (!we_q) rdata_d = bus.dat_i;
                    state_d  = ST_SEND_STATUS;
                end else if (wb_expired) begin
                    status_d = RSP_WBTO;
                    rdata_d  = 8'h00;
                    state_d  = ST_SEND_STATUS;
                end
            end
            ST_SEND_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status_q;
                if (bus.tx_ready) state_d = has_data_q ? ST_SEND_DATA : ST_IDLE;
            end
            ST_SEND_DATA: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q;
                if (bus.tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            status_q   <= '0;
            rdata_q    <= '0;
            has_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            has_data_q <= has_data_d;
        end
    end

    assign bus.stb_o    = (state_q == ST_WB_CYCLE);
    assign bus.adr_o    = adr_q;
    assign bus.dat_o    = dat_q;
    assign bus.we_o     = we_q;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data;
    assign bus.rx_drop  = rx_drop;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_glitch_host_bridge.sv
// Directed bench for glitch_host_bridge: TX bytes checked against an expected
// queue, with a Wishbone slave stub backed by a small register array.
module tb_glitch_host_bridge;
    import glitch_host_bridge_pkg::*;

    localparam logic [3:0] GLITCH_STATUS  = 4'h0;
    localparam logic [3:0] GLITCH_QUEUE_1 = 4'h2;

    logic          clk, rst;
    bridge_state_e dbg_state;
    glitch_host_bridge_if bus();

    glitch_host_bridge #(.WB_TIMEOUT(16), .RX_TIMEOUT(50)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem [16];
    logic       ack_en;
    int         ack_delay;
    int         cur_len = 0, last_len = 0, stb_total = 0, drop_cnt = 0, wr_cnt = 0, tx_cnt = 0;
    logic [3:0] cyc_adr;
    logic [7:0] cyc_dat;
    logic       cyc_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && bus.tx_valid == 1'b0) && n < bound) begin
            step();
            n++;
        end
        check(tag, 32'(n < bound), 32'd1);
    endtask

    // Slave stub, stb/rx_drop counters and TX scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        bus.ack_i = 1'b0;
        if (!rst && bus.stb_o) begin
            cur_len++;
            last_len = cur_len;
            stb_total++;
            if (cur_len == 1) begin
                cyc_adr = bus.adr_o;
                cyc_dat = bus.dat_o;
                cyc_we  = bus.we_o;
            end else begin
                check("wb_adr_stable", 32'(bus.adr_o), 32'(cyc_adr));
                check("wb_dat_stable", 32'(bus.dat_o), 32'(cyc_dat));
                check("wb_we_stable", 32'(bus.we_o), 32'(cyc_we));
            end
            if (ack_en && cur_len == ack_delay) begin
                bus.ack_i = 1'b1;
                if (bus.we_o) begin
                    mem[bus.adr_o] = bus.dat_o;
                    wr_cnt++;
                end
            end
        end else begin
            cur_len = 0;
        end
        bus.dat_i = mem[bus.adr_o];
        if (!rst && bus.rx_drop) drop_cnt++;
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            tx_cnt++;
            check("tx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, w0, t0, n;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[GLITCH_STATUS] = 8'h01;
        mem[5]             = 8'h5A;
        ack_en       = 1'b1;
        ack_delay    = 1;
        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) step();
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_stb", 32'(bus.stb_o), 32'd0);
        check("rst_we", 32'(bus.we_o), 32'd0);
        check("rst_adr", 32'(bus.adr_o), 32'd0);
        check("rst_dat", 32'(bus.dat_o), 32'd0);
        check("rst_drop", 32'(bus.rx_drop), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        step();

        // Read of the status register
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        send_byte({4'h0, GLITCH_STATUS});
        check("rd_stb_latency", 32'(bus.stb_o), 32'd1);
        check("rd_we", 32'(bus.we_o), 32'd0);
        check("rd_adr", 32'(bus.adr_o), 32'(GLITCH_STATUS));
        wait_done("rd_done", 40);
        check("rd_stb_len", 32'(last_len), 32'd1);

        // Write of queue 1 with a slow ack
        ack_delay = 3;
        w0 = wr_cnt;
        exp_q.push_back(8'hA5);
        send_byte({4'h8, GLITCH_QUEUE_1});
        check("wr_no_stb_before_data", 32'(bus.stb_o), 32'd0);
        send_byte(8'h02);
        check("wr_stb_latency", 32'(bus.stb_o), 32'd1);
        check("wr_we", 32'(bus.we_o), 32'd1);
        check("wr_dat", 32'(bus.dat_o), 32'h02);
        check("wr_adr", 32'(bus.adr_o), 32'(GLITCH_QUEUE_1));
        wait_done("wr_done", 40);
        check("wr_count", 32'(wr_cnt), 32'(w0 + 1));
        check("wr_mem", 32'(mem[GLITCH_QUEUE_1]), 32'h02);

        // Read with ack arriving on the fourth stb cycle
        ack_delay = 4;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        send_byte(8'h05);
        wait_done("rd5_done", 40);
        check("rd5_stb_len", 32'(last_len), 32'd4);

        // Ack exactly in the timeout cycle still counts as success
        ack_delay = 16;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        send_byte({4'h0, GLITCH_STATUS});
        wait_done("rd_edge_done", 60);
        check("rd_edge_stb_len", 32'(last_len), 32'd16);

        // No-ack slave: timeout
        ack_en = 1'b0;
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'h00);
        send_byte({4'h0, GLITCH_STATUS});
        wait_done("wbto_done", 60);
        check("wbto_stb_len", 32'(last_len), 32'd16);
        check("wbto_stb_low", 32'(bus.stb_o), 32'd0);
        ack_en = 1'b1;
        ack_delay = 1;

        // Bad command, then a dropped byte under backpressure
        bus.tx_ready = 1'b0;
        s0 = stb_total;
        d0 = drop_cnt;
        exp_q.push_back(8'hE1);
        send_byte(8'h30);
        check("bad_tx_valid", 32'(bus.tx_valid), 32'd1);
        check("bad_tx_data", 32'(bus.tx_data), 32'hE1);
        send_byte(8'h55);
        repeat (3) step();
        check("bad_drop_once", 32'(drop_cnt), 32'(d0 + 1));
        check("bad_tx_held", 32'(bus.tx_data), 32'hE1);
        check("bad_no_stb", 32'(stb_total), 32'(s0));
        bus.tx_ready = 1'b1;
        wait_done("bad_done", 20);

        // Backpressure on a read response
        bus.tx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        send_byte({4'h0, GLITCH_STATUS});
        n = 0;
        while (!bus.tx_valid && n < 40) begin
            step();
            n++;
        end
        check("bp_tx_valid_seen", 32'(n < 40), 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("bp_tx_valid_hold", 32'(bus.tx_valid), 32'd1);
            check("bp_tx_data_hold", 32'(bus.tx_data), 32'hA5);
            step();
        end
        bus.tx_ready = 1'b1;
        wait_done("bp_done", 20);

        // Reset during a Wishbone cycle
        ack_en = 1'b0;
        t0 = tx_cnt;
        send_byte({4'h0, GLITCH_STATUS});
        check("rstmid_stb_high", 32'(bus.stb_o), 32'd1);
        rst = 1'b1;
        step();
        check("rstmid_stb_low", 32'(bus.stb_o), 32'd0);
        check("rstmid_tx_valid", 32'(bus.tx_valid), 32'd0);
        rst = 1'b0;
        repeat (25) step();
        check("rstmid_no_tx", 32'(tx_cnt), 32'(t0));
        check("rstmid_idle", 32'(dbg_state), 32'(ST_IDLE));
        ack_en = 1'b1;

`ifdef GLITCH_BRIDGE_RXTO_EN
        // Missing data byte: RX timeout after 50 cycles, then a normal read
        s0 = stb_total;
        exp_q.push_back(8'hE2);
        send_byte(8'h81);
        n = 0;
        while (!bus.tx_valid && n < 200) begin
            step();
            n++;
        end
        check("rxto_latency", 32'(n), 32'd50);
        check("rxto_tx_data", 32'(bus.tx_data), 32'hE2);
        wait_done("rxto_done", 20);
        check("rxto_no_stb", 32'(stb_total), 32'(s0));
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        send_byte({4'h0, GLITCH_STATUS});
        wait_done("rxto_next_done", 40);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
